// File: rtl/fpu_mul_exp_ctl.sv
// Sequencing/control for the FP multiply exponent pipe (m1..m6); 8-step issue-to-result latency.
// All stage records advance together on m6stg_step; a valid m6 result held by the consumer stalls the whole pipe.
module fpu_mul_exp_ctl (
    input  logic        rclk,
    input  logic        reset,
    input  logic        inq_mul_vld,
    input  logic [1:0]  inq_op,
    input  logic        inq_in1_infnan,
    input  logic        inq_in2_infnan,
    input  logic        inq_in1_zero,
    input  logic        inq_in2_zero,
    input  logic        inq_sign,
    input  logic [1:0]  inq_rnd_mode,
    input  logic        mul_out_rdy,
    input  logic [12:0] m5stg_exp,
    output logic        mul_inq_rdy,
    output logic        m6stg_step,
    output logic        fmul_clken_l,
    output logic        m1stg_dblop,
    output logic        m1stg_sngop,
    output logic        m1stg_fsmuld,
    output logic        m2stg_exp_expadd,
    output logic        m2stg_exp_0bff,
    output logic        m2stg_exp_017f,
    output logic        m2stg_exp_04ff,
    output logic        m2stg_exp_zero,
    output logic        m2stg_fmuld,
    output logic        m2stg_fmuls,
    output logic        m2stg_fsmuld,
    output logic        m5stg_fmuld,
    output logic        m5stg_in_of,
    output logic        m5stg_to_0_inv,
    output logic        mul_exp_out_exp,
    output logic        mul_exp_out_exp_plus1,
    output logic        mul_out_vld
);
    typedef enum logic [1:0] {CLS_NORM = 2'd0, CLS_MAX = 2'd1, CLS_ZERO = 2'd2} cls_e;

    typedef struct packed {
        logic       vld;
        logic [1:0] op;
        cls_e       cls;
        logic       sign;
        logic [1:0] rnd;
    } rec_t;

    localparam logic [1:0] OP_FMULS  = 2'b01;
    localparam logic [1:0] OP_FMULD  = 2'b10;
    localparam logic [1:0] OP_FSMULD = 2'b11;
    localparam int NSTG = 8;  // index 0 = m1 ... 6 = m5, 7 = m6

    rec_t        r_stg [NSTG];
    rec_t        w_issue;
    logic        w_accept;
    logic        w_any_vld;
    logic        w_of;
    logic        w_to_0;
    logic [11:0] w_of_thr;

    assign m6stg_step  = !r_stg[NSTG-1].vld | mul_out_rdy;
    assign mul_inq_rdy = m6stg_step;
    assign w_accept    = inq_mul_vld & m6stg_step & (inq_op != 2'b00);

    always_comb begin
        w_issue      = '0;
        w_issue.vld  = w_accept;
        w_issue.op   = inq_op;
        w_issue.sign = inq_sign;
        w_issue.rnd  = inq_rnd_mode;
        if (inq_in1_infnan | inq_in2_infnan)
            w_issue.cls = CLS_MAX;
        else if (inq_in1_zero | inq_in2_zero)
            w_issue.cls = CLS_ZERO;
        else
            w_issue.cls = CLS_NORM;
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int i = 0; i < NSTG; i++) r_stg[i] <= '0;
        end else if (m6stg_step) begin
            r_stg[0] <= w_issue;
            for (int i = 1; i < NSTG; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    always_comb begin
        w_any_vld = 1'b0;
        for (int i = 0; i < NSTG; i++) w_any_vld = w_any_vld | r_stg[i].vld;
    end

    assign fmul_clken_l = !(inq_mul_vld | w_any_vld);

    assign m1stg_dblop  = r_stg[0].vld & (r_stg[0].op == OP_FMULD);
    assign m1stg_sngop  = r_stg[0].vld & ((r_stg[0].op == OP_FMULS) | (r_stg[0].op == OP_FSMULD));
    assign m1stg_fsmuld = r_stg[0].vld & (r_stg[0].op == OP_FSMULD);

    // Exponent source for m2 is chosen while the op still sits in m1
    assign m2stg_exp_expadd = r_stg[0].vld & (r_stg[0].cls == CLS_NORM);
    assign m2stg_exp_zero   = r_stg[0].vld & (r_stg[0].cls == CLS_ZERO);
    assign m2stg_exp_0bff   = r_stg[0].vld & (r_stg[0].cls == CLS_MAX) & (r_stg[0].op == OP_FMULD);
    assign m2stg_exp_017f   = r_stg[0].vld & (r_stg[0].cls == CLS_MAX) & (r_stg[0].op == OP_FMULS);
    assign m2stg_exp_04ff   = r_stg[0].vld & (r_stg[0].cls == CLS_MAX) & (r_stg[0].op == OP_FSMULD);

    assign m2stg_fmuld  = r_stg[1].vld & (r_stg[1].op == OP_FMULD);
    assign m2stg_fmuls  = r_stg[1].vld & (r_stg[1].op == OP_FMULS);
    assign m2stg_fsmuld = r_stg[1].vld & (r_stg[1].op == OP_FSMULD);

    // fsmuld produces a double result, so it shares the double overflow threshold
    assign w_of_thr = (r_stg[6].op == OP_FMULS) ? 12'h0ff : 12'h7ff;
    assign w_of     = r_stg[6].vld & (r_stg[6].cls == CLS_NORM) & !m5stg_exp[12]
                    & (m5stg_exp[11:0] >= w_of_thr);
    assign w_to_0   = (r_stg[6].rnd == 2'b01)
                    | ((r_stg[6].rnd == 2'b10) & r_stg[6].sign)
                    | ((r_stg[6].rnd == 2'b11) & !r_stg[6].sign);

    assign m5stg_fmuld           = r_stg[6].vld & (r_stg[6].op != OP_FMULS);
    assign m5stg_in_of           = w_of;
    assign m5stg_to_0_inv        = !(w_of & w_to_0);
    assign mul_exp_out_exp       = r_stg[6].vld & (r_stg[6].cls != CLS_NORM);
    assign mul_exp_out_exp_plus1 = r_stg[6].vld & (r_stg[6].cls == CLS_NORM) & !w_of;

    assign mul_out_vld = r_stg[NSTG-1].vld;
endmodule
